// File: rtl/ssd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ssd_pkg
// Description : Shared digit-select constants and helpers for the seven-
//               segment scan controller.
// Revision    : 1.0 - initial release
// ============================================================================
package ssd_pkg;

    localparam int unsigned SSD_DIGITS = 4;

    typedef logic [1:0] ssd_idx_t;
    typedef logic [3:0] ssd_sel_t;

    // Active-low digit selects: all off, and one-cold per digit position.
    localparam ssd_sel_t SSD_CTL_OFF  = 4'b1111;
    localparam ssd_sel_t SSD_SEL_DIG0 = 4'b1110;
    localparam ssd_sel_t SSD_SEL_DIG1 = 4'b1101;
    localparam ssd_sel_t SSD_SEL_DIG2 = 4'b1011;
    localparam ssd_sel_t SSD_SEL_DIG3 = 4'b0111;

    function automatic ssd_sel_t ssd_onecold(input ssd_idx_t idx);
        ssd_sel_t sel;
        case (idx)
            2'd0:    sel = SSD_SEL_DIG0;
            2'd1:    sel = SSD_SEL_DIG1;
            2'd2:    sel = SSD_SEL_DIG2;
            default: sel = SSD_SEL_DIG3;
        endcase
        return sel;
    endfunction

    function automatic logic [3:0] ssd_digit(input logic [15:0] word, input ssd_idx_t idx);
        return word[{idx, 2'b00} +: 4];
    endfunction

endpackage
`default_nettype wire

// File: rtl/ssd_scan_ctrl_tick_gen.sv
`default_nettype none
// ============================================================================
// Module      : scan_tick_gen
// Description : Free-running slot prescaler, counts 0..SCAN_DIV-1 and flags
//               the terminal count.
// Revision    : 1.0 - initial release
// ============================================================================
module scan_tick_gen #(
    parameter int unsigned SCAN_DIV = 100000,
    parameter int unsigned CNT_W    = $clog2(SCAN_DIV)
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic [CNT_W-1:0] count,
    output logic             tick
);

    localparam logic [CNT_W-1:0] c_last = CNT_W'(SCAN_DIV - 1);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (r_count == c_last) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign count = r_count;
    assign tick  = (r_count == c_last);

endmodule
`default_nettype wire

// File: rtl/ssd_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ssd_scan_ctrl
// Description : Four-digit multiplexed seven-segment scan controller with
//               frame-synchronous display update and blank guard cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module ssd_scan_ctrl
    import ssd_pkg::*;
#(
    parameter int unsigned SCAN_DIV = 100000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] value,
    input  logic        load,
    input  logic [3:0]  digit_en,
    output logic [3:0]  nibble,
    output logic [3:0]  ssd_ctl,
    output logic        frame_done
);

    localparam int unsigned CNT_W = $clog2(SCAN_DIV);

    logic [CNT_W-1:0] w_cnt;
    logic             w_tick;
    logic [CNT_W-1:0] w_cnt_nxt;
    ssd_idx_t         w_idx_nxt;
    logic             w_boundary;
    logic [15:0]      w_active_nxt;
    logic             w_blank_nxt;

    ssd_idx_t         r_idx;
    logic [15:0]      r_active;
    logic [15:0]      r_pending;
    logic             r_pend_vld;
    logic [3:0]       r_nibble;
    ssd_sel_t         r_ssd_ctl;
    logic             r_frame_done;

    scan_tick_gen #(
        .SCAN_DIV (SCAN_DIV),
        .CNT_W    (CNT_W)
    ) u_tick_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .count (w_cnt),
        .tick  (w_tick)
    );

    // Outputs are registered from the next state so they line up with it.
    always_comb begin
        w_cnt_nxt    = w_tick ? '0 : w_cnt + CNT_W'(1);
        w_idx_nxt    = w_tick ? r_idx + 2'd1 : r_idx;
        w_boundary   = w_tick && (r_idx == 2'd3);
        w_active_nxt = r_active;
        if (w_boundary) begin
            if (load) begin
                w_active_nxt = value;
            end else if (r_pend_vld) begin
                w_active_nxt = r_pending;
            end
        end
        w_blank_nxt  = (w_cnt_nxt == '0) || !digit_en[w_idx_nxt];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_idx        <= 2'd0;
            r_active     <= 16'h0000;
            r_pending    <= 16'h0000;
            r_pend_vld   <= 1'b0;
            r_nibble     <= 4'h0;
            r_ssd_ctl    <= SSD_CTL_OFF;
            r_frame_done <= 1'b0;
        end else begin
            r_idx        <= w_idx_nxt;
            r_active     <= w_active_nxt;
            r_nibble     <= ssd_digit(w_active_nxt, w_idx_nxt);
            r_ssd_ctl    <= w_blank_nxt ? SSD_CTL_OFF : ssd_onecold(w_idx_nxt);
            r_frame_done <= w_boundary;
            // A load landing on the boundary bypasses the pending register.
            if (w_boundary) begin
                r_pend_vld <= 1'b0;
            end else if (load) begin
                r_pending  <= value;
                r_pend_vld <= 1'b1;
            end
        end
    end

    assign nibble     = r_nibble;
    assign ssd_ctl    = r_ssd_ctl;
    assign frame_done = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_ssd_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_ssd_scan_ctrl
// Description : Directed self-checking bench for ssd_scan_ctrl, SCAN_DIV=4.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ssd_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] value = 16'h0000;
    logic        load = 1'b0;
    logic [3:0]  digit_en = 4'b1111;
    logic [3:0]  nibble;
    logic [3:0]  ssd_ctl;
    logic        frame_done;

    int n_vec = 0;
    int n_err = 0;

    // One nibble per cycle of a 16-cycle frame, cycle 0 in the top nibble.
    logic [63:0] c_ctl_all;
    logic [63:0] c_ctl_en0101;

    ssd_scan_ctrl #(.SCAN_DIV(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .value      (value),
        .load       (load),
        .digit_en   (digit_en),
        .nibble     (nibble),
        .ssd_ctl    (ssd_ctl),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        load  = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        load  = 1'b1;
        value = 16'hFFFF;
        tick();
        tick();
        tick();
        n_vec++;
        if (ssd_ctl !== 4'b1111) begin
            n_err++;
            $display("FAIL reset_ctl got %b want 1111", ssd_ctl);
        end
        n_vec++;
        if (nibble !== 4'h0) begin
            n_err++;
            $display("FAIL reset_nibble got %h want 0", nibble);
        end
        n_vec++;
        if (frame_done !== 1'b0) begin
            n_err++;
            $display("FAIL reset_done got %b want 0", frame_done);
        end
        load  = 1'b0;
        value = 16'h0000;
    endtask

    // Continues from test_reset: release with no load, loaded-in-reset value must not show.
    task automatic test_first_frame();
        rst_n = 1'b1;
        for (int c = 0; c < 16; c++) begin
            n_vec++;
            if (ssd_ctl !== c_ctl_all[(15-c)*4 +: 4]) begin
                n_err++;
                $display("FAIL first_frame_ctl c=%0d got %b want %b", c, ssd_ctl, c_ctl_all[(15-c)*4 +: 4]);
            end
            n_vec++;
            if (nibble !== 4'h0) begin
                n_err++;
                $display("FAIL first_frame_nibble c=%0d got %h want 0", c, nibble);
            end
            n_vec++;
            if (frame_done !== 1'b0) begin
                n_err++;
                $display("FAIL first_frame_done c=%0d got %b want 0", c, frame_done);
            end
            tick();
        end
    endtask

    task automatic test_single_load();
        logic [63:0] nib_seq;
        nib_seq = 64'h4444_3333_2222_1111;
        do_reset();
        for (int c = 0; c < 32; c++) begin
            load  = (c == 3);
            value = (c == 3) ? 16'h1234 : 16'h0000;
            n_vec++;
            if (ssd_ctl !== c_ctl_all[(15-(c%16))*4 +: 4]) begin
                n_err++;
                $display("FAIL single_load_ctl c=%0d got %b want %b", c, ssd_ctl, c_ctl_all[(15-(c%16))*4 +: 4]);
            end
            n_vec++;
            if (nibble !== ((c < 16) ? 4'h0 : nib_seq[(15-(c%16))*4 +: 4])) begin
                n_err++;
                $display("FAIL single_load_nibble c=%0d got %h want %h", c, nibble,
                         (c < 16) ? 4'h0 : nib_seq[(15-(c%16))*4 +: 4]);
            end
            n_vec++;
            if (frame_done !== (c == 16)) begin
                n_err++;
                $display("FAIL single_load_done c=%0d got %b want %b", c, frame_done, (c == 16));
            end
            tick();
        end
        load = 1'b0;
    endtask

    task automatic test_last_wins();
        logic [63:0] nib_seq;
        nib_seq = 64'hBBBB_5555_BBBB_5555;
        do_reset();
        for (int c = 0; c < 32; c++) begin
            load = (c == 2) || (c == 9);
            value = (c == 2) ? 16'hAAAA : ((c == 9) ? 16'h5B5B : 16'h0000);
            n_vec++;
            if (nibble !== ((c < 16) ? 4'h0 : nib_seq[(15-(c%16))*4 +: 4])) begin
                n_err++;
                $display("FAIL last_wins_nibble c=%0d got %h want %h", c, nibble,
                         (c < 16) ? 4'h0 : nib_seq[(15-(c%16))*4 +: 4]);
            end
            tick();
        end
        load = 1'b0;
    endtask

    // A pending 1111 is superseded by C0DE on the boundary and must not reappear.
    task automatic test_boundary_load();
        logic [63:0] nib_seq;
        nib_seq = 64'hEEEE_DDDD_0000_CCCC;
        do_reset();
        for (int c = 0; c < 48; c++) begin
            load  = (c == 5) || (c == 15);
            value = (c == 5) ? 16'h1111 : ((c == 15) ? 16'hC0DE : 16'h0000);
            n_vec++;
            if (nibble !== ((c < 16) ? 4'h0 : nib_seq[(15-(c%16))*4 +: 4])) begin
                n_err++;
                $display("FAIL boundary_load_nibble c=%0d got %h want %h", c, nibble,
                         (c < 16) ? 4'h0 : nib_seq[(15-(c%16))*4 +: 4]);
            end
            n_vec++;
            if (frame_done !== ((c == 16) || (c == 32))) begin
                n_err++;
                $display("FAIL boundary_load_done c=%0d got %b want %b", c, frame_done, (c == 16) || (c == 32));
            end
            tick();
        end
        load = 1'b0;
    endtask

    task automatic test_digit_en();
        digit_en = 4'b0101;
        do_reset();
        for (int c = 0; c < 32; c++) begin
            n_vec++;
            if (ssd_ctl !== c_ctl_en0101[(15-(c%16))*4 +: 4]) begin
                n_err++;
                $display("FAIL digit_en_ctl c=%0d got %b want %b", c, ssd_ctl, c_ctl_en0101[(15-(c%16))*4 +: 4]);
            end
            n_vec++;
            if (frame_done !== (c == 16)) begin
                n_err++;
                $display("FAIL digit_en_done c=%0d got %b want %b", c, frame_done, (c == 16));
            end
            tick();
        end
        digit_en = 4'b1111;
    endtask

    task automatic test_reset_midframe();
        do_reset();
        for (int c = 0; c < 9; c++) begin
            load  = (c == 3);
            value = (c == 3) ? 16'h9876 : 16'h0000;
            tick();
        end
        load  = 1'b0;
        rst_n = 1'b0;
        tick();
        n_vec++;
        if (ssd_ctl !== 4'b1111) begin
            n_err++;
            $display("FAIL midreset_ctl got %b want 1111", ssd_ctl);
        end
        n_vec++;
        if (nibble !== 4'h0) begin
            n_err++;
            $display("FAIL midreset_nibble got %h want 0", nibble);
        end
        rst_n = 1'b1;
        for (int c = 0; c < 32; c++) begin
            n_vec++;
            if (ssd_ctl !== c_ctl_all[(15-(c%16))*4 +: 4]) begin
                n_err++;
                $display("FAIL midreset_frame_ctl c=%0d got %b want %b", c, ssd_ctl, c_ctl_all[(15-(c%16))*4 +: 4]);
            end
            n_vec++;
            if (nibble !== 4'h0) begin
                n_err++;
                $display("FAIL midreset_frame_nibble c=%0d got %h want 0", c, nibble);
            end
            n_vec++;
            if (frame_done !== (c == 16)) begin
                n_err++;
                $display("FAIL midreset_frame_done c=%0d got %b want %b", c, frame_done, (c == 16));
            end
            tick();
        end
    endtask

    initial begin
        c_ctl_all    = 64'hFEEE_FDDD_FBBB_F777;
        c_ctl_en0101 = 64'hFEEE_FFFF_FBBB_FFFF;
        test_reset();
        test_first_frame();
        test_single_load();
        test_last_wins();
        test_boundary_load();
        test_digit_en();
        test_reset_midframe();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ssd_scan_ctrl.md
SSD_SCAN_CTRL -- requirements
Module: ssd_scan_ctrl

Interface
REQ-001 SHALL provide parameter SCAN_DIV, default 100000, clk cycles per digit slot; legal range 2..2^20.
REQ-002 SHALL provide port clk, input, 1, single system clock; all state updates on rising edge.
REQ-003 SHALL provide port rst_n, input, 1, reset, synchronous and active-low.
REQ-004 SHALL provide port value, input, 16, four hex digits; [3:0] = digit 0 (rightmost) .. [15:12] = digit 3.
REQ-005 SHALL provide port load, input, 1, one-cycle strobe capturing value.
REQ-006 SHALL provide port digit_en, input, 4, per-digit enable; 0 blanks that digit.
REQ-007 SHALL provide port nibble, output, 4, hex code of the current digit, fed to the hex-to-segment decoder.
REQ-008 SHALL provide port ssd_ctl, output, 4, active-low digit select, one-cold; 4'b1111 = all digits off.
REQ-009 SHALL provide port frame_done, output, 1, one-cycle pulse at each frame boundary.

Function
REQ-010 SHALL keep a prescaler counting 0..SCAN_DIV-1 and wrapping to 0; terminal count advances digit index idx 0->1->2->3->0.
REQ-011 SHALL define a frame as 4 slots (idx 0..3), i.e. 4*SCAN_DIV cycles; slot timing SHALL NOT depend on digit_en or load.
REQ-012 SHALL register all outputs; outputs describe the current (prescaler, idx) state in the same cycle.
REQ-013 SHALL drive ssd_ctl = 4'b1111 in prescaler cycle 0 of every slot (anti-ghosting blank cycle).
REQ-014 SHALL drive ssd_ctl = 4'b1111 for the whole slot when digit_en[idx]=0, with digit_en sampled each cycle.
REQ-015 Otherwise, SHALL drive ssd_ctl = one-cold(idx): idx0 -> 4'b1110, idx1 -> 4'b1101, idx2 -> 4'b1011, idx3 -> 4'b0111.
REQ-016 SHALL drive nibble = active[4*idx+3 : 4*idx] for every cycle of the slot, including blank cycles.
REQ-017 load SHALL copy value into a pending register and set a pending flag; a later load before the boundary overwrites it (last wins).
REQ-018 At the frame boundary (idx 3 -> 0 transition edge), SHALL copy pending into active and clear the flag; without pending, active SHALL hold.
REQ-019 When load coincides with the boundary edge, value SHALL go directly to active and the pending flag SHALL clear.
REQ-020 SHALL assert frame_done for exactly the first cycle of slot 0 after each 3 -> 0 wrap; it SHALL NOT pulse for the slot 0 that follows reset.
REQ-021 SHALL never drive more than one ssd_ctl bit low in any cycle.

Reset
REQ-022 rst_n=0 at a clock edge SHALL set prescaler=0, idx=0, active=16'h0000, pending=16'h0000, pending flag=0.
REQ-023 During and after reset, SHALL output nibble=4'h0, ssd_ctl=4'b1111, frame_done=0.
REQ-024 Reset mid-frame SHALL abandon the slot, discard any pending load, and restart at slot 0 cycle 0.

Structure
REQ-025 SHALL place the one-cold digit-select patterns and the SSD_CTL_OFF=4'b1111 constant in shared package ssd_pkg.
REQ-026 SHALL implement the prescaler as sub-module scan_tick_gen (parameter SCAN_DIV; outputs count and tick).
REQ-027 SHALL keep the hex-to-segment decoding outside this block; nibble connects to it directly.

Verification (SCAN_DIV=4)
REQ-028 Reset release, no load -> first frame: each slot has 1 blank cycle, then 3 cycles of 1110/1101/1011/0111; nibble=0; no frame_done at cycle 0.
REQ-029 load 16'h1234 in frame 1 -> frame 2: slot0 nibble=4, slot1 nibble=3, slot2 nibble=2, slot3 nibble=1; frame_done high in cycle 16 only.
REQ-030 load 16'hAAAA then load 16'h5B5B in the same frame -> next frame shows B,5,B,5; 16'hAAAA is never displayed.
REQ-031 load 16'hC0DE on the 3->0 boundary edge -> the slot 0 that starts on that edge shows nibble=E.
REQ-032 digit_en=4'b0101 -> slots 1 and 3 show ssd_ctl=1111 for all 4 cycles; slots 0 and 2 are unaffected; frame length stays 16 cycles.
REQ-033 rst_n=0 in slot 2 with a pending load -> next cycle: ssd_ctl=1111, nibble=0, idx=0; the pending value is never displayed.
